decode_stage: RTL and testbench

Second pipeline stage, directly downstream of the fetch stage. Accepts the fetched instruction and its PC, decodes the opcode into a control bundle, and reads two operands from the 32×32 register file. It owns that register file and its write-back port. Detects load-use hazards, stalls fetch, and registers everything into the ID/EX stage register consumed by the execute stage.

---
 rtl/decode_stage.sv | 216 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with register file, load-use hazard detection and ID/EX register
//
// Purpose:
//   Decodes the fetched instruction into a control bundle and reads two
//   operands from the 32x32 register file, which this stage owns together
//   with its write-back port. A load-use hazard inserts one bubble and stalls
//   fetch. The result is registered into the ID/EX stage register.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   if_valid/if_pc/if_instr      instruction from fetch
//   flush                        kill the instruction being decoded
//   ex_stall                     hold ID/EX
//   ex_is_load/ex_rd             load currently in execute (hazard source)
//   wb_en/wb_addr/wb_data        register file write port
//   stall_fetch                  combinational fetch hold
//   id_*                         ID/EX bundle
//
// Optional feature:
//   DECODE_WB_BYPASS_EN - when defined, a same-cycle write is bypassed onto
//   the operand read (write-first). Otherwise reads return the pre-write value.

module decode_stage #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_instr,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,
    output logic              stall_fetch,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [6:0]        id_opcode,
    output logic [4:0]        id_rd,
    output logic [31:0]       id_rs1_val,
    output logic [31:0]       id_rs2_val,
    output logic [31:0]       id_imm,
    output logic              id_reg_wr,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic              id_byte,
    output logic              id_branch,
    output logic              id_jump,
    output logic              id_illegal
);

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_LDB  = 7'h10;
    localparam logic [6:0] OP_LDW  = 7'h11;
    localparam logic [6:0] OP_STB  = 7'h12;
    localparam logic [6:0] OP_STW  = 7'h13;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [31:0]       rs1_val;
        logic [31:0]       rs2_val;
        logic [31:0]       imm;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic              byte_acc;
        logic              branch;
        logic              jump;
        logic              illegal;
    } idex_t;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [14:0] br_off;

    assign opcode = if_instr[31:25];
    assign rd     = if_instr[24:20];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[14:10];
    assign br_off = {if_instr[24:20], if_instr[9:0]};

    // Register file
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != 5'd0) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                     (wb_en && wb_addr == rs1) ? wb_data : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                     (wb_en && wb_addr == rs2) ? wb_data : regs_q[rs2];
`else
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
`endif

    // Hazard compares raw rs fields regardless of opcode: conservative, never misses a real dependency.
    logic hazard;
    assign hazard = if_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));

    // A flush redirects fetch, so the hazard must not hold it back.
    assign stall_fetch = ex_stall || (hazard && !flush);

    idex_t dec;

    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.opcode  = opcode;
        dec.rd      = rd;
        dec.rs1_val = rs1_val;
        dec.rs2_val = rs2_val;
        dec.imm     = {{17{if_instr[14]}}, if_instr[14:0]};
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_MOV: dec.reg_wr = 1'b1;
            OP_LDB: begin
                dec.mem_rd   = 1'b1;
                dec.reg_wr   = 1'b1;
                dec.byte_acc = 1'b1;
            end
            OP_LDW: begin
                dec.mem_rd = 1'b1;
                dec.reg_wr = 1'b1;
            end
            OP_STB: begin
                dec.mem_wr   = 1'b1;
                dec.byte_acc = 1'b1;
            end
            OP_STW:  dec.mem_wr = 1'b1;
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.imm    = {{17{br_off[14]}}, br_off};
            end
            OP_JUMP: dec.jump    = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

    idex_t idex_q;
    idex_t idex_d;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (ex_stall) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d = '0;
        end else if (if_valid) begin
            idex_d = dec;
        end else begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_valid   = idex_q.valid;
    assign id_pc      = idex_q.pc;
    assign id_opcode  = idex_q.opcode;
    assign id_rd      = idex_q.rd;
    assign id_rs1_val = idex_q.rs1_val;
    assign id_rs2_val = idex_q.rs2_val;
    assign id_imm     = idex_q.imm;
    assign id_reg_wr  = idex_q.reg_wr;
    assign id_mem_rd  = idex_q.mem_rd;
    assign id_mem_wr  = idex_q.mem_wr;
    assign id_byte    = idex_q.byte_acc;
    assign id_branch  = idex_q.branch;
    assign id_jump    = idex_q.jump;
    assign id_illegal = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with behavioural reference model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        ex_stall;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_fetch;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic        id_reg_wr;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic        id_byte;
    logic        id_branch;
    logic        id_jump;
    logic        id_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush), .ex_stall(ex_stall),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_fetch(stall_fetch),
        .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_byte(id_byte), .id_branch(id_branch), .id_jump(id_jump),
        .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        bt;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bun_t;

    bun_t        act_b;
    bun_t        exp_b;
    logic [31:0] mregs [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign act_b = {id_valid, id_pc, id_opcode, id_rd, id_rs1_val, id_rs2_val, id_imm,
                    id_reg_wr, id_mem_rd, id_mem_wr, id_byte, id_branch, id_jump, id_illegal};

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] r1, input logic [4:0] r2,
                                        input logic [9:0] low);
        return {op, rd, r1, r2, low};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == r) return wb_data;
`endif
        return mregs[r];
    endfunction

    function automatic bun_t model_decode();
        bun_t        b;
        logic [14:0] off;
        b         = '0;
        b.valid   = 1'b1;
        b.pc      = if_pc;
        b.op      = if_instr[31:25];
        b.rd      = if_instr[24:20];
        b.a       = model_read(if_instr[19:15]);
        b.b       = model_read(if_instr[14:10]);
        b.imm     = {{17{if_instr[14]}}, if_instr[14:0]};
        off       = {if_instr[24:20], if_instr[9:0]};
        case (b.op)
            7'h00, 7'h01, 7'h02, 7'h14: b.reg_wr = 1'b1;
            7'h10: begin b.mem_rd = 1'b1; b.reg_wr = 1'b1; b.bt = 1'b1; end
            7'h11: begin b.mem_rd = 1'b1; b.reg_wr = 1'b1; end
            7'h12: begin b.mem_wr = 1'b1; b.bt = 1'b1; end
            7'h13: b.mem_wr = 1'b1;
            7'h30: begin b.branch = 1'b1; b.imm = {{17{off[14]}}, off}; end
            7'h31: b.jump = 1'b1;
            default: b.illegal = 1'b1;
        endcase
        return b;
    endfunction

    function automatic bit model_hazard();
        return if_valid && ex_is_load && ex_rd != 5'd0 &&
               (ex_rd == if_instr[19:15] || ex_rd == if_instr[14:10]);
    endfunction

    // Reference model: evaluates the priority rules on the inputs seen at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_b <= '0;
            for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
        end else begin
            if (flush)               exp_b <= '0;
            else if (ex_stall)       exp_b <= exp_b;
            else if (model_hazard()) exp_b <= '0;
            else if (if_valid)       exp_b <= model_decode();
            else                     exp_b <= '0;
            if (wb_en && wb_addr != 5'd0) mregs[wb_addr] <= wb_data;
        end
    end

    // Per-cycle compare; inputs change only at posedge+2, so they are still the sampled ones here.
    always @(posedge clk) begin
        #1;
        check("id_bundle", act_b, exp_b);
        check("stall_fetch", stall_fetch, ex_stall || (model_hazard() && !flush));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        if_valid = 0; if_pc = 0; if_instr = 0; flush = 0; ex_stall = 0;
        ex_is_load = 0; ex_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    logic [6:0] op_tab [11];

    initial begin
        op_tab = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h30, 7'h31, 7'h7F};
        reset = 1'b0;
        idle();
        repeat (3) cyc();
        check("reset_id_valid", id_valid, 1'b0);
        check("reset_id_pc", id_pc, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            if_valid = 1; if_instr = enc(7'h14, 5'd1, 5'(i), 5'(31 - i), 10'd0); if_pc = 32'(i * 4);
            cyc();
            check("reset_reg_read", {id_rs1_val, id_rs2_val}, 64'd0);
        end
        idle();

        wb_en = 1; wb_addr = 5'd3; wb_data = 32'd5;
        cyc();
        wb_addr = 5'd4; wb_data = 32'd7;
        cyc();
        wb_en = 0;

        if_valid = 1; if_instr = enc(7'h00, 5'd5, 5'd3, 5'd4, 10'd0); if_pc = 32'h1000;
        cyc();
        check("add_valid", id_valid, 1'b1);
        check("add_pc", id_pc, 32'h1000);
        check("add_rs1", id_rs1_val, 32'd5);
        check("add_rs2", id_rs2_val, 32'd7);
        check("add_reg_wr", id_reg_wr, 1'b1);
        check("add_rd", id_rd, 5'd5);

        if_pc = 32'h1004; ex_is_load = 1; ex_rd = 5'd3;
        #1 check("hazard_stall", stall_fetch, 1'b1);
        cyc();
        check("hazard_bubble", id_valid, 1'b0);
        ex_is_load = 0;
        #1 check("hazard_release", stall_fetch, 1'b0);
        cyc();
        check("hazard_issue_valid", id_valid, 1'b1);
        check("hazard_issue_pc", id_pc, 32'h1004);

        if_instr = enc(7'h11, 5'd6, 5'd3, 5'd0, 10'd0); flush = 1; ex_stall = 1;
        cyc();
        check("flush_valid", id_valid, 1'b0);
        check("flush_mem_rd", id_mem_rd, 1'b0);
        ex_stall = 0;
        if_instr = enc(7'h00, 5'd5, 5'd3, 5'd4, 10'd0); ex_is_load = 1; ex_rd = 5'd4;
        #1 check("flush_hazard_stall", stall_fetch, 1'b0);
        cyc();
        flush = 0; ex_is_load = 0;

        if_instr = enc(7'h11, 5'd6, 5'd3, 5'd0, 10'd0);
        cyc();
        check("ldw_mem_rd", id_mem_rd, 1'b1);
        ex_stall = 1; if_instr = enc(7'h12, 5'd0, 5'd3, 5'd4, 10'd0);
        cyc();
        check("stall_hold", {id_mem_rd, id_mem_wr, id_byte}, 3'b100);
        ex_stall = 0;

        if_instr = enc(7'h14, 5'd8, 5'd7, 5'd0, 10'd0);
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        cyc();
`ifdef DECODE_WB_BYPASS_EN
        check("bypass_r7", id_rs1_val, 32'hDEAD_BEEF);
`else
        check("bypass_r7", id_rs1_val, 32'd0);
`endif
        wb_en = 0;
        cyc();
        check("r7_after_write", id_rs1_val, 32'hDEAD_BEEF);
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        if_instr = enc(7'h14, 5'd8, 5'd0, 5'd0, 10'd0);
        cyc();
        wb_en = 0;
        cyc();
        check("r0_zero", {id_rs1_val, id_rs2_val}, 64'd0);

        if_instr = enc(7'h7F, 5'd2, 5'd3, 5'd4, 10'd0);
        cyc();
        check("illegal_flag", {id_valid, id_illegal}, 2'b11);
        check("illegal_ctrl", {id_reg_wr, id_mem_rd, id_mem_wr, id_byte, id_branch, id_jump}, 6'd0);

        if_instr = enc(7'h30, 5'b10000, 5'd3, 5'd4, 10'h001);
        cyc();
        check("beq_imm", id_imm, 32'hFFFF_C001);
        check("beq_branch", id_branch, 1'b1);

        for (int k = 0; k < 600; k++) begin
            if (k == 300) reset = 1'b0;
            if (k == 302) reset = 1'b1;
            if_valid   = ($urandom_range(0, 9) < 8);
            if_instr   = enc(op_tab[$urandom_range(0, 10)], 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 10'($urandom));
            if_pc      = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            ex_stall   = ($urandom_range(0, 6) == 0);
            ex_is_load = ($urandom_range(0, 4) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            wb_en      = ($urandom_range(0, 1) == 1);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            cyc();
        end
        idle();
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
